sprite_motion_ctrl: RTL and testbench

Per-frame sprite motion and animation controller that drives the position, action and orientation inputs of the tile/sprite pixel stage in the VGA/HDMI path. It samples left/right push-buttons once per video frame on the rising edge of vsync. It moves the 32-px-wide walker horizontally with clamping at screen limits, and steps through walk-cycle sprite columns. It also selects the facing direction.

---
 rtl/sprite_motion_ctrl.sv | 149 ++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion/animation controller: samples buttons on each vsync
// rising edge, moves the walker with clamping, and steps walk-cycle columns.
module sprite_motion_ctrl #(
  parameter int SPEED       = 2,
  parameter int POS_MIN     = 0,
  parameter int POS_MAX     = 448,
  parameter int POS_INIT    = 64,
  parameter int WALK_FRAMES = 4,
  parameter int FRAME_DIV   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [8:0] position,
  output logic [2:0] action,
  output logic       orientation,
  output logic       moving
);

  typedef enum logic {
    S_IDLE,
    S_WALK
  } state_t;

  localparam logic [9:0] L_SPEED10   = 10'(SPEED);
  localparam logic [8:0] L_SPEED9    = 9'(SPEED);
  localparam logic [9:0] L_MAX10     = 10'(POS_MAX);
  localparam logic [8:0] L_MAX9      = 9'(POS_MAX);
  localparam logic [8:0] L_MIN9      = 9'(POS_MIN);
  localparam logic [9:0] L_LEFT_LIM  = 10'(POS_MIN + SPEED);
  localparam logic [8:0] L_INIT      = 9'(POS_INIT);
  localparam logic [5:0] L_DIV_LAST  = 6'(FRAME_DIV - 1);
  localparam logic [2:0] L_WALK_LAST = 3'(WALK_FRAMES);

  logic       r_l_meta, r_l_s, r_r_meta, r_r_s;
  logic       r_vsync_q;
  state_t     r_state, w_state_nxt;
  logic [8:0] r_position, w_position_nxt;
  logic [2:0] r_action, w_action_nxt;
  logic       r_orientation, w_orientation_nxt;
  logic       r_moving, w_moving_nxt;
  logic [5:0] r_div_cnt, w_div_cnt_nxt;

  logic       w_tick, w_dir_r, w_dir_l, w_move;
  logic [9:0] w_sum;
  logic [8:0] w_right_next, w_left_next, w_target;

  assign w_tick  = vsync & ~r_vsync_q;
  assign w_dir_r = r_r_s & ~r_l_s;
  assign w_dir_l = r_l_s & ~r_r_s;

  // 10-bit sum so the right clamp sees values past 511 without wrapping.
  assign w_sum        = {1'b0, r_position} + L_SPEED10;
  assign w_right_next = (w_sum > L_MAX10) ? L_MAX9 : w_sum[8:0];
  assign w_left_next  = ({1'b0, r_position} < L_LEFT_LIM) ? L_MIN9 : (r_position - L_SPEED9);
  assign w_target     = w_dir_r ? w_right_next : w_left_next;

  // Pushing into a limit already reached counts as no direction at all.
  assign w_move = (w_dir_r & (r_position != L_MAX9)) | (w_dir_l & (r_position != L_MIN9));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain the synchronizer into one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_l_meta      <= 1'b0;
      r_l_s         <= 1'b0;
      r_r_meta      <= 1'b0;
      r_r_s         <= 1'b0;
      r_vsync_q     <= 1'b0;
      r_state       <= S_IDLE;
      r_position    <= L_INIT;
      r_action      <= 3'd0;
      r_orientation <= 1'b1;
      r_moving      <= 1'b0;
      r_div_cnt     <= 6'd0;
    end else begin
      r_l_meta      <= btn_left;
      r_l_s         <= r_l_meta;
      r_r_meta      <= btn_right;
      r_r_s         <= r_r_meta;
      r_vsync_q     <= vsync;
      r_state       <= w_state_nxt;
      r_position    <= w_position_nxt;
      r_action      <= w_action_nxt;
      r_orientation <= w_orientation_nxt;
      r_moving      <= w_moving_nxt;
      r_div_cnt     <= w_div_cnt_nxt;
    end
  end

  // NOTE: every next-state value is defaulted to its current value first, so no
  // path through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt       = r_state;
    w_position_nxt    = r_position;
    w_action_nxt      = r_action;
    w_orientation_nxt = r_orientation;
    w_moving_nxt      = r_moving;
    w_div_cnt_nxt     = r_div_cnt;

    if (w_tick) begin
      if (w_dir_r) begin
        w_orientation_nxt = 1'b1;
      end else if (w_dir_l) begin
        w_orientation_nxt = 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_move) begin
            w_state_nxt    = S_WALK;
            w_position_nxt = w_target;
            w_action_nxt   = 3'd1;
            w_div_cnt_nxt  = 6'd0;
            w_moving_nxt   = 1'b1;
          end else begin
            w_action_nxt = 3'd0;
          end
        end
        S_WALK: begin
          if (w_move) begin
            w_position_nxt = w_target;
            // A reversal keeps the animation phase; only orientation flips.
            if (r_div_cnt == L_DIV_LAST) begin
              w_div_cnt_nxt = 6'd0;
              w_action_nxt  = (r_action == L_WALK_LAST) ? 3'd1 : r_action + 3'd1;
            end else begin
              w_div_cnt_nxt = r_div_cnt + 6'd1;
            end
          end else begin
            w_state_nxt   = S_IDLE;
            w_action_nxt  = 3'd0;
            w_div_cnt_nxt = 6'd0;
            w_moving_nxt  = 1'b0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign position    = r_position;
  assign action      = r_action;
  assign orientation = r_orientation;
  assign moving      = r_moving;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: default instance plus two instances
// started near the left and right limits, all driven by the same stimulus.
module tb_sprite_motion_ctrl;

  logic clk = 1'b0;
  logic reset, vsync, btn_left, btn_right;

  logic [8:0] pos_m, pos_l, pos_r;
  logic [2:0] act_m, act_l, act_r;
  logic       ori_m, ori_l, ori_r;
  logic       mov_m, mov_l, mov_r;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sprite_motion_ctrl dut_m (
    .clk(clk), .reset(reset), .vsync(vsync), .btn_left(btn_left), .btn_right(btn_right),
    .position(pos_m), .action(act_m), .orientation(ori_m), .moving(mov_m)
  );

  sprite_motion_ctrl #(.POS_INIT(3)) dut_l (
    .clk(clk), .reset(reset), .vsync(vsync), .btn_left(btn_left), .btn_right(btn_right),
    .position(pos_l), .action(act_l), .orientation(ori_l), .moving(mov_l)
  );

  sprite_motion_ctrl #(.POS_INIT(447)) dut_r (
    .clk(clk), .reset(reset), .vsync(vsync), .btn_left(btn_left), .btn_right(btn_right),
    .position(pos_r), .action(act_r), .orientation(ori_r), .moving(mov_r)
  );

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic [8:0] p, input logic [2:0] a,
                           input logic o, input logic m,
                           input int ep, input int ea, input int eo, input int em);
    check({tag, ".position"}, 16'(p), 16'(ep));
    check({tag, ".action"}, 16'(a), 16'(ea));
    check({tag, ".orientation"}, 16'(o), 16'(eo));
    check({tag, ".moving"}, 16'(m), 16'(em));
  endtask

  // One vsync pulse of one clk; returns at a negedge two clocks after the tick edge.
  task automatic do_tick();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_buttons(input logic l, input logic r);
    @(negedge clk);
    btn_left  = l;
    btn_right = r;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk) vsync = ~vsync;
    reset = 1'b0;
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; btn_left = 1'b0; btn_right = 1'b1;

    // Reset held 3 clk with vsync toggling and right pressed: no tick effect.
    repeat (3) @(negedge clk) vsync = ~vsync;
    check_out("reset_hold", pos_m, act_m, ori_m, mov_m, 64, 0, 1, 0);
    reset = 1'b0; vsync = 1'b0; btn_right = 1'b0;
    repeat (4) @(negedge clk);
    check_out("after_reset", pos_m, act_m, ori_m, mov_m, 64, 0, 1, 0);

    // Walk right 25 ticks: 2 px/tick, action steps every 6 ticks, wraps 4 -> 1.
    set_buttons(1'b0, 1'b1);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk) vsync = 1'b1;
      // Still the pre-tick value at the negedge before the tick edge.
      if (k == 1) check("pre_tick_pos", 16'(pos_m), 16'd64);
      @(negedge clk) vsync = 1'b0;
      check($sformatf("walk_r%0d.position", k), 16'(pos_m), 16'(64 + 2 * k));
      check($sformatf("walk_r%0d.action", k), 16'(act_m), 16'(((k - 1) / 6) % 4 + 1));
      if (k == 1 || k == 13 || k == 25) begin
        check($sformatf("walk_r%0d.orientation", k), 16'(ori_m), 16'd1);
        check($sformatf("walk_r%0d.moving", k), 16'(mov_m), 16'd1);
      end
      repeat (2) @(negedge clk);
    end
    check("hold_between_ticks", 16'(pos_m), 16'd114);

    // Release: back to stand, position unchanged.
    set_buttons(1'b0, 1'b0);
    do_tick();
    check_out("release", pos_m, act_m, ori_m, mov_m, 114, 0, 1, 0);

    // Walk right 10 ticks -> action 2, div_cnt 3, position 134.
    set_buttons(1'b0, 1'b1);
    repeat (10) do_tick();
    check_out("pre_reverse", pos_m, act_m, ori_m, mov_m, 134, 2, 1, 1);

    // Reverse: phase continues, action 3 on the third left tick.
    set_buttons(1'b1, 1'b0);
    do_tick();
    check_out("reverse1", pos_m, act_m, ori_m, mov_m, 132, 2, 0, 1);
    do_tick();
    check_out("reverse2", pos_m, act_m, ori_m, mov_m, 130, 2, 0, 1);
    do_tick();
    check_out("reverse3", pos_m, act_m, ori_m, mov_m, 128, 3, 0, 1);

    // vsync held high 100 clk yields a single update.
    @(negedge clk) vsync = 1'b1;
    repeat (100) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    check_out("vsync_held", pos_m, act_m, ori_m, mov_m, 126, 3, 0, 1);

    // Reset mid-walk: reset values visible one clk later.
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check_out("reset_mid_walk", pos_m, act_m, ori_m, mov_m, 64, 0, 1, 0);
    reset = 1'b0;
    btn_left = 1'b0;
    repeat (2) @(negedge clk);

    // Left clamp from 3: 1, 0 (still walking), then blocked -> idle.
    do_reset();
    set_buttons(1'b1, 1'b0);
    do_tick();
    check_out("lclamp1", pos_l, act_l, ori_l, mov_l, 1, 1, 0, 1);
    do_tick();
    check_out("lclamp2", pos_l, act_l, ori_l, mov_l, 0, 1, 0, 1);
    do_tick();
    check_out("lclamp3", pos_l, act_l, ori_l, mov_l, 0, 0, 0, 0);

    // Right clamp from 447: 448 (walking), then blocked -> idle.
    set_buttons(1'b0, 1'b0);
    do_reset();
    set_buttons(1'b0, 1'b1);
    do_tick();
    check_out("rclamp1", pos_r, act_r, ori_r, mov_r, 448, 1, 1, 1);
    do_tick();
    check_out("rclamp2", pos_r, act_r, ori_r, mov_r, 448, 0, 1, 0);

    // Step left once, then both buttons: no motion, orientation stays left.
    set_buttons(1'b1, 1'b0);
    do_tick();
    check_out("rstep_left", pos_r, act_r, ori_r, mov_r, 446, 1, 0, 1);
    set_buttons(1'b1, 1'b1);
    do_tick();
    check_out("both_pressed", pos_r, act_r, ori_r, mov_r, 446, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
